pal_cfg_loader: RTL and testbench

Configuration bitstream transmitter for the PAL fabric. It accepts configuration data as parallel words over a valid/ready handshake and serializes them one bit per clock onto the PAL's serial configuration input. After the last configuration bit it raises the apply/enable level, so the loaded AND/OR planes take effect. It sits between the host-side configuration source (SPI bridge, ROM sequencer or test port) and the PAL's CFG/EN pins.

---
 rtl/pal_pkg.sv | 24 ++
 rtl/pal_cfg_loader_if.sv | 21 ++
 rtl/pal_cfg_crc8.sv | 26 ++
 rtl/pal_cfg_loader.sv | 124 ++++++++++++
 tb/tb_pal_cfg_loader.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pal_pkg.sv
// Shared types and constants for the PAL configuration loader.
// Build option: PAL_CFG_CRC_EN adds CRC-8 checking of the bitstream.
package pal_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_CHECK,
    ST_APPLY,
    ST_ERROR
  } state_t;

  localparam logic [7:0] CRC_POLY = 8'h07;

  function automatic int cfg_bits(
    input int n,
    input int p,
    input int m
  );
    return 2 * n * p + p * m;
  endfunction

endpackage

// File: rtl/pal_cfg_loader_if.sv
// Word handshake between the configuration source and the loader.
// Build option PAL_CFG_CRC_EN does not change this interface.
interface pal_cfg_loader_if #(
  parameter int W = 8
);
  logic [W-1:0] WORD_IN;
  logic         WORD_VALID;
  logic         WORD_READY;

  modport master (
    output WORD_IN,
    output WORD_VALID,
    input  WORD_READY
  );

  modport slave (
    input  WORD_IN,
    input  WORD_VALID,
    output WORD_READY
  );
endinterface

// File: rtl/pal_cfg_crc8.sv
// Serial CRC-8 (poly 0x07, init 0x00), one bit per enabled cycle.
// Only instantiated when PAL_CFG_CRC_EN is defined.
module pal_cfg_crc8
  import pal_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic fb;

  assign fb = crc[7] ^ bit_in;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= 8'h00;
    end else if (en) begin
      crc <= {crc[6:0], 1'b0} ^ (fb ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/pal_cfg_loader.sv
// Serializes configuration words onto the PAL CFG pin, then raises EN.
// Build option PAL_CFG_CRC_EN: trailing CRC-8 word checked before apply.
module pal_cfg_loader
  import pal_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 4,
  parameter int P = 15,
  parameter int W = 8
) (
  input  logic CLK,
  input  logic RES,
  input  logic START,
  pal_cfg_loader_if.slave wif,
  output logic CFG_OUT,
  output logic CFG_SHIFT,
  output logic CFG_APPLY,
  output logic BUSY,
  output logic ERR
);

  localparam int CFG_BITS = cfg_bits(N, P, M);
  localparam int CNT_W = $clog2(CFG_BITS + 1);
  localparam int IDX_W = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

  state_t           state, state_d;
  logic [W-1:0]     shreg, shreg_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic             clr;

  always_ff @(posedge CLK) begin
    if (RES) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
    end
  end

`ifdef PAL_CFG_CRC_EN
  logic [7:0] crc;

  pal_cfg_crc8 u_crc (
    .clk    (CLK),
    .rst    (RES),
    .clr    (clr),
    .en     (CFG_SHIFT),
    .bit_in (shreg[0]),
    .crc    (crc)
  );
`endif

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    cnt_d   = cnt;
    idx_d   = idx;
    clr     = 1'b0;
    unique case (state)
`ifdef PAL_CFG_CRC_EN
      ST_IDLE, ST_APPLY, ST_ERROR: begin
`else
      ST_IDLE, ST_APPLY: begin
`endif
        if (START) begin
          clr     = 1'b1;
          cnt_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (wif.WORD_VALID) begin
          shreg_d = wif.WORD_IN;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = shreg >> 1;
        cnt_d   = cnt + CNT_W'(1);
        idx_d   = idx + IDX_W'(1);
        if (cnt == CNT_LAST) begin
`ifdef PAL_CFG_CRC_EN
          state_d = ST_CHECK;
`else
          state_d = ST_APPLY;
`endif
        end else if (idx == IDX_LAST) begin
          state_d = ST_LOAD;
        end
      end
`ifdef PAL_CFG_CRC_EN
      ST_CHECK: begin
        if (wif.WORD_VALID) begin
          state_d = (wif.WORD_IN[7:0] == crc) ? ST_APPLY : ST_ERROR;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  assign wif.WORD_READY = (state == ST_LOAD) || (state == ST_CHECK);
  assign CFG_SHIFT = (state == ST_SHIFT);
  assign CFG_OUT   = CFG_SHIFT & shreg[0];
  // START drops EN in its own cycle so the PAL never runs a half-loaded plane
  assign CFG_APPLY = (state == ST_APPLY) & ~START;
  assign BUSY      = (state == ST_LOAD) || (state == ST_SHIFT) ||
                     (state == ST_CHECK);
`ifdef PAL_CFG_CRC_EN
  assign ERR = (state == ST_ERROR);
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Randomized scoreboard bench for pal_cfg_loader.
// Covers the PAL_CFG_CRC_EN build when that macro is defined.
module tb_pal_cfg_loader;
  import pal_pkg::*;

  localparam int W  = 8;
  localparam int NB = 2 * 8 * 15 + 15 * 4;
  localparam int NW = (NB + W - 1) / W;

  logic CLK = 1'b0;
  logic RES = 1'b1;
  logic START = 1'b0;
  logic CFG_OUT, CFG_SHIFT, CFG_APPLY, BUSY, ERR;

  pal_cfg_loader_if #(.W(W)) wif ();

  pal_cfg_loader #(.N(8), .M(4), .P(15), .W(W)) dut (
    .CLK       (CLK),
    .RES       (RES),
    .START     (START),
    .wif       (wif),
    .CFG_OUT   (CFG_OUT),
    .CFG_SHIFT (CFG_SHIFT),
    .CFG_APPLY (CFG_APPLY),
    .BUSY      (BUSY),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  bit         exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         popped = 0;
  int         pushed = 0;
  bit         mon_en = 1'b0;
  bit         apply_due = 1'b0;
  bit         apply_seen = 1'b0;
  logic [7:0] crc_m = 8'h00;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // Monitor: every live bit is popped and compared with the model
  always @(negedge CLK) begin
    if (mon_en) begin
      if (CFG_SHIFT) begin
        if (exp_q.size() == 0) begin
          chk("extra_shift", 32'(popped), 32'(NB));
        end else begin
          chk("cfg_bit", 32'(CFG_OUT), 32'(exp_q.pop_front()));
        end
        chk("apply_during_shift", 32'(CFG_APPLY), 32'd0);
        popped++;
`ifndef PAL_CFG_CRC_EN
        apply_due = (popped == NB);
`endif
      end else begin
        chk("cfg_out_idle", 32'(CFG_OUT), 32'd0);
        if (apply_due) begin
          chk("apply_rise", 32'(CFG_APPLY), 32'd1);
          apply_due  = 1'b0;
          apply_seen = 1'b1;
        end
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input int stall,
                           input bit payload);
    int  t;
    bit  fb;
    if (stall > 0) begin
      t = 0;
      @(negedge CLK);
      while (!wif.WORD_READY && t < 40) begin
        @(negedge CLK);
        t++;
      end
      chk("stall_reach_load", 32'(wif.WORD_READY), 32'd1);
      repeat (stall) begin
        @(negedge CLK);
        chk("stall_no_shift", 32'(CFG_SHIFT), 32'd0);
      end
      @(posedge CLK);
      #1;
    end
    wif.WORD_IN    = d;
    wif.WORD_VALID = 1'b1;
    t = 0;
    @(negedge CLK);
    while (!wif.WORD_READY && t < 40) begin
      @(negedge CLK);
      t++;
    end
    if (!wif.WORD_READY) begin
      chk("handshake_timeout", 32'(wif.WORD_READY), 32'd1);
    end else if (payload) begin
      for (int i = 0; i < W; i++) begin
        if (pushed < NB) begin
          exp_q.push_back(d[i]);
          fb    = crc_m[7] ^ d[i];
          crc_m = {crc_m[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
          pushed++;
        end
      end
    end
    @(posedge CLK);
    #1;
    wif.WORD_VALID = 1'b0;
    wif.WORD_IN    = 8'($urandom);
  endtask

  task automatic do_reset(input int at_bit);
    int t;
    t = 0;
    while (popped < at_bit && t < 40) begin
      @(negedge CLK);
      t++;
    end
    chk("reach_reset_bit", 32'(popped >= at_bit), 32'd1);
    @(posedge CLK);
    #1;
    RES    = 1'b1;
    mon_en = 1'b0;
    @(posedge CLK);
    #1;
    RES = 1'b0;
    exp_q.delete();
    apply_due = 1'b0;
    @(negedge CLK);
    chk("rst_apply", 32'(CFG_APPLY), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_ready", 32'(wif.WORD_READY), 32'd0);
    chk("rst_shift", 32'(CFG_SHIFT), 32'd0);
    mon_en = 1'b1;
  endtask

  // mode: 0 = all 0xA5, 1 = random, 2 = all zero
  task automatic load(input int mode, input int stall_word,
                      input int start_word, input int rst_bit,
                      input bit bad);
    logic [7:0] d;
    int         t;
    @(posedge CLK);
    #1;
    START = 1'b1;
    popped = 0;
    pushed = 0;
    crc_m = 8'h00;
    exp_q.delete();
    apply_due = 1'b0;
    apply_seen = 1'b0;
    @(negedge CLK);
    chk("start_ready0", 32'(wif.WORD_READY), 32'd0);
    chk("apply_drop", 32'(CFG_APPLY), 32'd0);
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    chk("ready_after_start", 32'(wif.WORD_READY), 32'd1);
    chk("busy_after_start", 32'(BUSY), 32'd1);
    chk("err_after_start", 32'(ERR), 32'd0);
    @(posedge CLK);
    #1;
    for (int w = 0; w < NW; w++) begin
      d = (mode == 0) ? 8'hA5 : (mode == 1) ? 8'($urandom) : 8'h00;
      send_word(d, (w == stall_word) ? 5 : 0, 1'b1);
      if (w == start_word) begin
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
      end
      if (rst_bit > 0 && pushed > rst_bit) begin
        do_reset(rst_bit);
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK);
        #1;
      end
    end
`ifdef PAL_CFG_CRC_EN
    send_word(crc_m ^ {7'd0, bad}, 0, 1'b0);
    chk("bit_count", 32'(popped), 32'(NB));
    @(negedge CLK);
    chk("crc_apply", 32'(CFG_APPLY), 32'(!bad));
    chk("crc_err", 32'(ERR), 32'(bad));
`else
    t = 0;
    while (!apply_seen && t < 40) begin
      @(negedge CLK);
      t++;
    end
    chk("apply_seen", 32'(apply_seen), 32'd1);
    chk("bit_count", 32'(popped), 32'(NB));
    chk("bad_unused", 32'(bad), 32'd0);
`endif
    chk("leftover_bits", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    wif.WORD_VALID = 1'b0;
    wif.WORD_IN    = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_cfg_out", 32'(CFG_OUT), 32'd0);
    chk("rst_cfg_shift", 32'(CFG_SHIFT), 32'd0);
    chk("rst_cfg_apply", 32'(CFG_APPLY), 32'd0);
    chk("rst_busy0", 32'(BUSY), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    chk("rst_ready0", 32'(wif.WORD_READY), 32'd0);
    @(posedge CLK);
    #1;
    RES = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("idle_ready", 32'(wif.WORD_READY), 32'd0);
      chk("idle_busy", 32'(BUSY), 32'd0);
    end
    mon_en = 1'b1;

    load(0, 10, -1, 0, 1'b0);
    repeat (3) begin
      @(negedge CLK);
      chk("apply_hold", 32'(CFG_APPLY), 32'd1);
      chk("apply_busy", 32'(BUSY), 32'd0);
    end
    load(1, 20, 5, 0, 1'b0);
    load(1, -1, -1, 150, 1'b0);
    load(1, 3, -1, 0, 1'b0);
`ifdef PAL_CFG_CRC_EN
    load(2, -1, -1, 0, 1'b0);
    load(2, -1, -1, 0, 1'b1);
    load(1, -1, -1, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
